// File: rtl/fifo_write_drain.sv
// Drains a registered-output FIFO into a handshaked memory write port, one word per pop.
// A per-word WRITE timeout drops a stuck word and raises a sticky error flag.
module fifo_write_drain #(
  parameter int ADDR_BITS = 17,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [ADDR_BITS+DATA_BITS-1:0] fifo_rd_data,
  input  logic                           fifo_rd_empty,
  output logic                           fifo_rd_en,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [DATA_BITS-1:0]           mem_data,
  output logic                           mem_we,
  input  logic                           mem_ready,
  output logic                           busy,
  output logic [15:0]                    words_written,
  output logic                           err_timeout,
  input  logic                           clear_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, WRITE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                 state_reg, state_next;
  logic                   armed_reg;
  logic [7:0]             wr_cnt_reg;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic [DATA_BITS-1:0]   data_reg;
  logic [15:0]            words_reg;
  logic                   err_reg;
  logic                   accept;
  logic                   timeout;

  assign accept  = (state_reg == WRITE) && mem_ready;
  assign timeout = (state_reg == WRITE) && !mem_ready && (wr_cnt_reg >= TIMEOUT_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // armed_reg holds off the first pop until the second edge after reset release
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (armed_reg && enable && !fifo_rd_empty) state_next = CAPTURE;
      CAPTURE: state_next = WRITE;
      WRITE:   if (accept || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from state so an async reset drops them without a clock
  always_comb begin
    fifo_rd_en = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      CAPTURE: begin
        fifo_rd_en = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_reg  <= 1'b0;
      wr_cnt_reg <= 8'd0;
      addr_reg   <= '0;
      data_reg   <= '0;
      words_reg  <= 16'd0;
      err_reg    <= 1'b0;
    end else begin
      armed_reg <= 1'b1;

      if (state_reg == CAPTURE) begin
        addr_reg   <= fifo_rd_data[ADDR_BITS+DATA_BITS-1:DATA_BITS];
        data_reg   <= fifo_rd_data[DATA_BITS-1:0];
        wr_cnt_reg <= 8'd1;
      end else if (state_reg == WRITE) begin
        if (accept || timeout) wr_cnt_reg <= 8'd0;
        else                   wr_cnt_reg <= wr_cnt_reg + 8'd1;
      end

      if (accept) words_reg <= words_reg + 16'd1;

      // A timeout on the same edge as clear_err leaves the flag set
      if (timeout)        err_reg <= 1'b1;
      else if (clear_err) err_reg <= 1'b0;
    end
  end

  assign mem_addr      = addr_reg;
  assign mem_data      = data_reg;
  assign words_written = words_reg;
  assign err_timeout   = err_reg;

endmodule

// File: tb/tb_fifo_write_drain.sv
// Directed bench for fifo_write_drain: a queue models the registered-output FIFO,
// and every accepted memory write is checked against the order words were pushed.
module tb_fifo_write_drain;

  localparam int AB = 17;
  localparam int DB = 8;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [AB+DB-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_data;
  logic          mem_we;
  logic          mem_ready;
  logic          busy;
  logic [15:0]   words_written;
  logic          err_timeout;
  logic          clear_err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int pops = 0;
  int wr_cyc[$];
  logic [AB+DB-1:0] q[$];
  logic [AB+DB-1:0] exp_q[$];

  fifo_write_drain #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_en    (fifo_rd_en),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .mem_ready     (mem_ready),
    .busy          (busy),
    .words_written (words_written),
    .err_timeout   (err_timeout),
    .clear_err     (clear_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_rd_empty = (q.size() == 0);
    if (q.size() > 0) fifo_rd_data = q[0];
  endtask

  task automatic push(input logic [AB-1:0] a, input logic [DB-1:0] d);
    q.push_back({a, d});
    exp_q.push_back({a, d});
    refresh();
  endtask

  // One clock: sample handshakes before the edge, update the FIFO model after it
  task automatic tick();
    logic rd_s, wr_s;
    logic [AB+DB-1:0] w_s;
    logic [AB+DB-1:0] e;
    rd_s = fifo_rd_en;
    wr_s = mem_we && mem_ready;
    w_s  = {mem_addr, mem_data};
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s) begin
      pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
    refresh();
    if (wr_s) begin
      wr_cyc.push_back(cyc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("write_word", 32'(w_s), 32'(e));
      $display("cycle %0d: write addr=0x%05h data=0x%02h", cyc, w_s[AB+DB-1:DB], w_s[DB-1:0]);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; mem_ready = 1'b0; clear_err = 1'b0;
    fifo_rd_data = '0; fifo_rd_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_words", 32'(words_written), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_addr", 32'({mem_addr, mem_data}), 0);

    // Single word, ready tied high; no capture on the first edge after release
    push(17'h1ABCD, 8'h5A);
    reset_n = 1'b1; enable = 1'b1; mem_ready = 1'b1;
    tick();
    check("first_edge_idle", 32'(busy), 0);
    check("first_edge_rd_en", 32'(fifo_rd_en), 0);
    tick();
    check("capture_rd_en", 32'(fifo_rd_en), 1);
    check("capture_busy", 32'(busy), 1);
    tick();
    check("write_we", 32'(mem_we), 1);
    check("write_rd_en", 32'(fifo_rd_en), 0);
    check("write_addr", 32'(mem_addr), 32'h1ABCD);
    check("write_data", 32'(mem_data), 32'h5A);
    check("one_pop", 32'(pops), 1);
    tick();
    check("single_we_off", 32'(mem_we), 0);
    check("single_words", 32'(words_written), 1);
    check("single_idle", 32'(busy), 0);

    // Four queued words back to back, one every 3 cycles
    wr_cyc.delete();
    push(17'h00001, 8'h11);
    push(17'h1FFFF, 8'hFF);
    push(17'h12345, 8'h67);
    push(17'h0F0F0, 8'hA5);
    repeat (12) tick();
    check("burst_words", 32'(words_written), 5);
    check("burst_pops", 32'(pops), 5);
    check("burst_nwrites", 32'(wr_cyc.size()), 4);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("burst_period", 32'(wr_cyc[i] - wr_cyc[i-1]), 3);
    check("burst_drained", 32'(fifo_rd_empty), 1);

    // Ready low for 5 WRITE cycles then high; ready in CAPTURE must be ignored
    push(17'h0AAAA, 8'h3C);
    tick();
    check("stall_capture", 32'(fifo_rd_en), 1);
    mem_ready = 1'b0;
    tick();
    check("stall_ready_ignored", 32'(words_written), 5);
    for (int i = 0; i < 6; i++) begin
      check("stall_we", 32'(mem_we), 1);
      check("stall_hold", 32'({mem_addr, mem_data}), 32'({17'h0AAAA, 8'h3C}));
      if (i == 5) mem_ready = 1'b1;
      tick();
    end
    check("stall_we_off", 32'(mem_we), 0);
    check("stall_words", 32'(words_written), 6);
    check("stall_no_err", 32'(err_timeout), 0);

    // Ready stuck low: timeout after TO cycles, clear_err coincident with timeout loses
    mem_ready = 1'b0;
    push(17'h15555, 8'hC3);
    tick();
    tick();
    for (int i = 0; i < TO; i++) begin
      check("to_we", 32'(mem_we), 1);
      if (i == TO - 1) clear_err = 1'b1;
      tick();
    end
    clear_err = 1'b0;
    void'(exp_q.pop_front());
    check("to_we_off", 32'(mem_we), 0);
    check("to_err_set", 32'(err_timeout), 1);
    check("to_words", 32'(words_written), 6);
    check("to_idle", 32'(busy), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("to_err_clear", 32'(err_timeout), 0);

    // Enable low blocks draining; dropping it during CAPTURE does not abort
    enable = 1'b0;
    mem_ready = 1'b1;
    push(17'h00100, 8'h01);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_rd_en", 32'(fifo_rd_en), 0);
      check("hold_we", 32'(mem_we), 0);
    end
    enable = 1'b1;
    tick();
    check("resume_capture", 32'(fifo_rd_en), 1);
    enable = 1'b0;
    tick();
    check("resume_we", 32'(mem_we), 1);
    tick();
    check("resume_words", 32'(words_written), 7);
    tick();
    check("resume_stays_idle", 32'(busy), 0);

    // Async reset mid-WRITE drops mem_we before the next edge
    enable = 1'b1;
    mem_ready = 1'b0;
    push(17'h1CAFE, 8'h77);
    tick();
    tick();
    check("pre_rst_we", 32'(mem_we), 1);
    #3 reset_n = 1'b0;
    #1;
    check("async_we", 32'(mem_we), 0);
    check("async_busy", 32'(busy), 0);
    check("async_words", 32'(words_written), 0);
    check("async_addr", 32'({mem_addr, mem_data}), 0);
    void'(exp_q.pop_front());
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    push(17'h00042, 8'h24);
    tick();
    check("rerst_first_edge", 32'(busy), 0);
    tick();
    check("rerst_capture", 32'(fifo_rd_en), 1);
    tick();
    tick();
    check("rerst_words", 32'(words_written), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
